rand_range_sampler: RTL and testbench

//  Downstream consumer of the 16-bit LFSR stage.
//  - Turns raw pseudo-random words into unbiased values in [0, RANGE-1] (e.g. dice faces) by rejection sampling.
//  - Buffers accepted values in a small FIFO with a valid/ready output handshake.
//  - Keeps accept/reject statistics for debug.

---
 rtl/rand_pkg.sv | 20 ++
 rtl/rand_fifo.sv | 88 ++++++++
 rtl/rand_range_sampler.sv | 82 ++++++++
 tb/tb_rand_range_sampler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and helpers for the rejection-sampling random range block.
// The range limit is evaluated at elaboration time from W and RANGE.
package rand_pkg;

    localparam int unsigned RAND_W = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    // Largest multiple of range that fits in 2**w; words at or above it are biased.
    function automatic logic [63:0] calc_limit(input int unsigned w, input int unsigned range);
        logic [63:0] span;
        span = 64'd1 << w;
        return (span / 64'(range)) * 64'(range);
    endfunction

endpackage

// File: rtl/rand_fifo.sv
// Synchronous FIFO with EMPTY/PARTIAL/FULL occupancy FSM, push/pop/flush and count.
// Head data is forced to zero while empty so stale entries never appear on the output.
module rand_fifo
    import rand_pkg::*;
#(
    parameter  int unsigned DW    = 3,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    fifo_state_t   state_r;
    fifo_state_t   state_nxt_s;
    logic          push_s;
    logic          pop_s;

    assign pop_s      = pop && (state_r != EMPTY);
    assign push_s     = push && ((state_r != FULL) || pop_s);
    assign head_valid = (state_r != EMPTY);
    assign head_data  = head_valid ? mem_r[rd_ptr_r] : {DW{1'b0}};
    assign count      = count_r;

    // Occupancy FSM next state; push+pop holds, flush wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (push_s) state_nxt_s = PARTIAL;
                else        state_nxt_s = EMPTY;
            end
            PARTIAL: begin
                if (push_s && !pop_s && (count_r == CW'(DEPTH - 1)))
                    state_nxt_s = FULL;
                else if (pop_s && !push_s && (count_r == CW'(1)))
                    state_nxt_s = EMPTY;
                else
                    state_nxt_s = PARTIAL;
            end
            FULL: begin
                if (pop_s && !push_s) state_nxt_s = PARTIAL;
                else                  state_nxt_s = FULL;
            end
            default: state_nxt_s = EMPTY;
        endcase
        if (flush) state_nxt_s = EMPTY;
        else       state_nxt_s = state_nxt_s;
    end

    // Storage, pointers, count and state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= {DW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            state_r  <= EMPTY;
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            state_r  <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            if (push_s && !pop_s)      count_r <= count_r + CW'(1);
            else if (pop_s && !push_s) count_r <= count_r - CW'(1);
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// Rejection sampler: maps raw LFSR words to unbiased values in [0, RANGE-1],
// buffers them in a small FIFO and keeps accept/reject statistics.
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter  int unsigned W     = RAND_W,
    parameter  int unsigned RANGE = 6,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned VW    = $clog2(RANGE)
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [W-1:0]  rnd_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [VW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   acc_cnt,
    output logic [15:0]   rej_cnt
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [W:0]  LIMIT_C = (W + 1)'(calc_limit(W, RANGE));
    localparam logic [W-1:0] RANGE_C = W'(RANGE);

    logic          xfer_s;
    logic          acc_s;
    logic [VW-1:0] value_s;
    logic          stage_acc_r;
    logic [VW-1:0] stage_val_r;
    logic [CW-1:0] fifo_count_s;
    logic          pop_s;

    assign acc_s   = ({1'b0, rnd_in} < LIMIT_C);
    assign value_s = VW'(rnd_in % RANGE_C);
    // Credit counts the staged value but never a same-cycle pop, so the FIFO cannot overflow.
    assign in_ready = (({1'b0, fifo_count_s} + {{CW{1'b0}}, stage_acc_r}) < (CW + 1)'(DEPTH));
    assign xfer_s   = in_valid && in_ready && !flush;
    assign pop_s    = out_valid && out_ready;

    // Rejection stage register; flushed or idle cycles leave nothing pending.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stage_acc_r <= 1'b0;
            stage_val_r <= {VW{1'b0}};
        end else if (xfer_s) begin
            stage_acc_r <= acc_s;
            stage_val_r <= value_s;
        end else begin
            stage_acc_r <= 1'b0;
        end
    end

    // Statistics: accepted count wraps, rejected count saturates.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_cnt <= 16'd0;
            rej_cnt <= 16'd0;
        end else if (xfer_s) begin
            if (acc_s)                   acc_cnt <= acc_cnt + 16'd1;
            else if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
        end
    end

    rand_fifo #(
        .DW    (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .n_reset    (n_reset),
        .push       (stage_acc_r),
        .push_data  (stage_val_r),
        .pop        (pop_s),
        .flush      (flush),
        .head_data  (out_data),
        .head_valid (out_valid),
        .count      (fifo_count_s)
    );

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler (W=16, RANGE=6, DEPTH=4) with an LFSR-driven soak.
module tb_rand_range_sampler;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] rnd_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [2:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] acc_cnt;
    logic [15:0] rej_cnt;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [2:0]  got_q [$];
    logic [2:0]  exp_q [$];

    always #5 clk = ~clk;

    rand_range_sampler #(.W(16), .RANGE(6), .DEPTH(4)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .rnd_in    (rnd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt),
        .rej_cnt   (rej_cnt)
    );

    // Capture every value actually handed to the consumer.
    always @(negedge clk) begin
        if (n_reset && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int guard;
        guard    = 0;
        rnd_in   = w;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    initial begin
        logic [15:0] lfsr;
        logic [2:0]  exp4 [6];
        int          xfers;

        n_reset = 1'b0; rnd_in = 16'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        n_reset = 1'b1;
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_acc",       32'(acc_cnt),   32'd0);
        chk("rst_rej",       32'(rej_cnt),   32'd0);

        // 1: ACE1 -> 1, two-cycle latency
        out_ready = 1'b1;
        rnd_in = 16'hACE1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_lat_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(out_data),  32'd1);
        chk("t1_acc",   32'(acc_cnt),   32'd1);
        step();

        // 2: E270 -> 2, FFFB (just under limit) -> 5
        got_q.delete();
        send(16'hE270);
        send(16'hFFFB);
        repeat (4) step();
        chk("t2_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("t2_first",  32'(got_q[0]), 32'd2);
            chk("t2_second", 32'(got_q[1]), 32'd5);
        end
        chk("t2_rej", 32'(rej_cnt), 32'd0);
        chk("t2_acc", 32'(acc_cnt), 32'd3);

        // 3: FFFC (== limit) and FFFF rejected
        got_q.delete();
        send(16'hFFFC);
        send(16'hFFFF);
        repeat (4) step();
        chk("t3_no_out", 32'(got_q.size()), 32'd0);
        chk("t3_rej",    32'(rej_cnt),      32'd2);
        chk("t3_acc",    32'(acc_cnt),      32'd3);
        chk("t3_valid",  32'(out_valid),    32'd0);

        // 4: backpressure, credit stops after four transfers
        got_q.delete();
        out_ready = 1'b0;
        exp4[0] = 3'd4; exp4[1] = 3'd5; exp4[2] = 3'd0;
        exp4[3] = 3'd1; exp4[4] = 3'd2; exp4[5] = 3'd3;
        for (int i = 0; i < 4; i++) send(16'd10 + 16'(i));
        chk("t4_ready_low", 32'(in_ready), 32'd0);
        repeat (3) step();
        chk("t4_ready_held", 32'(in_ready),  32'd0);
        chk("t4_valid",      32'(out_valid), 32'd1);
        chk("t4_hold_data",  32'(out_data),  32'd4);
        out_ready = 1'b1;
        send(16'd14);
        send(16'd15);
        repeat (10) step();
        chk("t4_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            chk("t4_order", 32'(got_q[i]), 32'(exp4[i]));
        chk("t4_acc", 32'(acc_cnt), 32'd9);

        // 5: flush with a concurrent input transfer
        out_ready = 1'b0;
        send(16'd20);
        send(16'd21);
        send(16'd22);
        repeat (2) step();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        chk("t5_pre_ready", 32'(in_ready),  32'd1);
        flush = 1'b1; rnd_in = 16'd23; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready),  32'd1);
        chk("t5_acc",   32'(acc_cnt),   32'd12);
        chk("t5_rej",   32'(rej_cnt),   32'd2);
        repeat (3) step();
        chk("t5_still_empty", 32'(out_valid), 32'd0);

        // 6: LFSR soak with random backpressure against a scoreboard
        got_q.delete();
        exp_q.delete();
        lfsr  = 16'hACE1;
        xfers = 0;
        for (int c = 0; c < 1000; c++) begin
            rnd_in    = lfsr;
            in_valid  = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_ready) begin
                xfers++;
                if (lfsr < 16'd65532) exp_q.push_back(3'(lfsr % 16'd6));
                lfsr = lfsr_next(lfsr);
            end
            step();
            if (out_valid) chk("t6_range", 32'(out_data < 3'd6), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("t6_seq_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("t6_seq", 32'(got_q[i]), 32'(exp_q[i]));
        chk("t6_stat_sum", 32'(acc_cnt) + 32'(rej_cnt), 32'(14 + xfers));

        // Reset pulse with traffic in flight
        out_ready = 1'b0;
        rnd_in    = lfsr;
        in_valid  = 1'b1;
        repeat (5) step();
        n_reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data",  32'(out_data),  32'd0);
        chk("t6_rst_acc",   32'(acc_cnt),   32'd0);
        chk("t6_rst_rej",   32'(rej_cnt),   32'd0);
        chk("t6_rst_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        step();
        n_reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
